regfile_param: RTL and testbench

REGFILE_PARAM -- requirements
Module: regfile_param

---
 rtl/regfile_param.sv | 104 ++++++++++
 tb/tb_regfile_param.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_param.sv
// Parameterised register file with x0 hardwiring, write-through bypass,
// a per-register pending-write scoreboard and a post-reset clear sequence.
module regfile_param #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] rd_data1,
  output logic [XLEN-1:0] rd_data2,
  input  logic            regWr,
  input  logic [AW-1:0]   ws,
  input  logic [XLEN-1:0] wr_data,
  input  logic            rsv_en,
  input  logic [AW-1:0]   rsv_rd,
  output logic            busy1,
  output logic            busy2,
  output logic            init_done
);

  typedef enum logic {CLEAR, RUN} state_t;

  localparam logic [AW-1:0] LAST = AW'(NREG - 1);

  state_t          state_q;
  state_t          state_d;
  logic [AW-1:0]   clr_idx;
  logic            clr_we;
  logic            run;
  logic            wr_acc;
  logic            rsv_acc;
  logic            byp1;
  logic            byp2;
  logic [NREG-1:0] sb;
  logic [XLEN-1:0] regs [NREG];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= CLEAR;
      clr_idx   <= '0;
      init_done <= 1'b0;
    end else begin
      state_q   <= state_d;
      init_done <= (state_d == RUN);
      if (state_q == CLEAR)
        clr_idx <= clr_idx + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CLEAR: if (clr_idx == LAST) state_d = RUN;
      RUN:   state_d = RUN;
      default: state_d = CLEAR;
    endcase
  end

  always_comb begin
    clr_we = (state_q == CLEAR);
    run    = (state_q == RUN);
  end

  assign wr_acc  = run && regWr && (ws != '0);
  assign rsv_acc = run && rsv_en && (rsv_rd != '0);
  assign byp1    = wr_acc && (ws == rs1);
  assign byp2    = wr_acc && (ws == rs2);

  // Array is deliberately unreset; the CLEAR walk zeroes it.
  always_ff @(posedge clk) begin
    if (clr_we)
      regs[clr_idx] <= '0;
    else if (wr_acc)
      regs[ws] <= wr_data;
  end

  // Set is applied after clear so a reissued producer keeps the bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sb <= '0;
    end else begin
      if (wr_acc)
        sb[ws] <= 1'b0;
      if (rsv_acc)
        sb[rsv_rd] <= 1'b1;
    end
  end

  always_comb begin
    rd_data1 = '0;
    rd_data2 = '0;
    if (run && rs1 != '0)
      rd_data1 = byp1 ? wr_data : regs[rs1];
    if (run && rs2 != '0)
      rd_data2 = byp2 ? wr_data : regs[rs2];
  end

  assign busy1 = run && sb[rs1] && !byp1;
  assign busy2 = run && sb[rs2] && !byp2;

endmodule

// File: tb/tb_regfile_param.sv
// Randomised and directed bench for regfile_param against a
// behavioural register/scoreboard model.
module tb_regfile_param;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs1, rs2, ws, rsv_rd;
  logic [31:0] rd_data1, rd_data2, wr_data;
  logic        regWr, rsv_en;
  logic        busy1, busy2, init_done;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_reg [32];
  bit   [31:0] m_sb;
  bit          m_run;
  int          m_clr;

  always #5 clk = ~clk;

  regfile_param #(.XLEN(32), .NREG(32), .AW(5)) dut (
    .clk(clk), .reset(reset),
    .rs1(rs1), .rs2(rs2),
    .rd_data1(rd_data1), .rd_data2(rd_data2),
    .regWr(regWr), .ws(ws), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_rd(rsv_rd),
    .busy1(busy1), .busy2(busy2),
    .init_done(init_done)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (!m_run || a == 0) return 32'h0;
    if (regWr && ws == a) return wr_data;
    return m_reg[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    if (!m_run || a == 0) return 1'b0;
    if (regWr && ws == a) return 1'b0;
    return m_sb[a];
  endfunction

  task automatic set_reset(input logic v);
    reset = v;
    if (!v) begin
      m_run = 0;
      m_clr = 0;
      m_sb  = '0;
    end
  endtask

  // Advance the model by one edge using the inputs held before it.
  task automatic tick();
    if (!reset) begin
      m_run = 0;
      m_clr = 0;
      m_sb  = '0;
    end else if (!m_run) begin
      m_clr++;
      if (m_clr == 32) begin
        m_run = 1;
        foreach (m_reg[i]) m_reg[i] = 32'h0;
      end
    end else begin
      if (regWr && ws != 0) begin
        m_reg[ws] = wr_data;
        m_sb[ws]  = 1'b0;
      end
      if (rsv_en && rsv_rd != 0)
        m_sb[rsv_rd] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    regWr  = 1'b0;
    rsv_en = 1'b0;
    ws     = '0;
    rsv_rd = '0;
  endtask

  task automatic check_ports(input string tag);
    #1;
    chk({tag, "_rd1"}, rd_data1, exp_rd(rs1));
    chk({tag, "_rd2"}, rd_data2, exp_rd(rs2));
    chk({tag, "_b1"}, busy1, exp_busy(rs1));
    chk({tag, "_b2"}, busy2, exp_busy(rs2));
    chk({tag, "_done"}, init_done, m_run);
  endtask

  task automatic scan_all(input string tag);
    idle();
    for (int i = 0; i < 32; i++) begin
      rs1 = 5'(i);
      rs2 = 5'(31 - i);
      check_ports(tag);
    end
  endtask

  task automatic run_clear(input string tag, input bit poke);
    int n = 0;
    while (!init_done && n < 100) begin
      if (poke) begin
        regWr   = 1'b1;
        ws      = 5'd3;
        wr_data = $urandom;
        rsv_en  = 1'b1;
        rsv_rd  = 5'd4;
        rs1     = 5'd3;
        rs2     = 5'd4;
        #1;
        chk({tag, "_clr_rd"}, rd_data1, 32'h0);
        chk({tag, "_clr_busy"}, busy2, 1'b0);
      end
      tick();
      n++;
    end
    idle();
    chk({tag, "_clr_len"}, n, 32);
  endtask

  initial begin
    idle();
    rs1 = '0;
    rs2 = '0;
    wr_data = '0;
    m_sb = '0;
    m_run = 0;
    m_clr = 0;
    foreach (m_reg[i]) m_reg[i] = 32'h0;
    set_reset(1'b0);
    tick();
    tick();
    rs1 = 5'd5;
    rs2 = 5'd9;
    #1;
    chk("rst_init_done", init_done, 1'b0);
    chk("rst_rd1", rd_data1, 32'h0);
    chk("rst_busy1", busy1, 1'b0);

    set_reset(1'b1);
    run_clear("boot", 1'b1);
    scan_all("boot_scan");

    regWr = 1'b1; ws = 5'd5; wr_data = 32'hDEADBEEF; rs1 = 5'd5;
    #1;
    chk("byp_same", rd_data1, 32'hDEADBEEF);
    tick();
    idle();
    #1;
    chk("byp_next", rd_data1, 32'hDEADBEEF);

    regWr = 1'b1; ws = 5'd0; wr_data = 32'hFFFFFFFF;
    rsv_en = 1'b1; rsv_rd = 5'd0; rs1 = 5'd0;
    #1;
    chk("x0_rd", rd_data1, 32'h0);
    chk("x0_busy", busy1, 1'b0);
    tick();
    idle();
    #1;
    chk("x0_rd_after", rd_data1, 32'h0);
    chk("x0_busy_after", busy1, 1'b0);

    rsv_en = 1'b1; rsv_rd = 5'd7; rs1 = 5'd7;
    #1;
    chk("sb_same_cycle", busy1, 1'b0);
    tick();
    idle();
    #1;
    chk("sb_set", busy1, 1'b1);
    regWr = 1'b1; ws = 5'd7; wr_data = 32'h00001234;
    #1;
    chk("sb_wr_mask", busy1, 1'b0);
    tick();
    idle();
    #1;
    chk("sb_cleared", busy1, 1'b0);
    chk("sb_data", rd_data1, 32'h00001234);

    rsv_en = 1'b1; rsv_rd = 5'd9;
    tick();
    regWr = 1'b1; ws = 5'd9; wr_data = 32'hCAFE0009;
    rsv_en = 1'b1; rsv_rd = 5'd9;
    tick();
    idle();
    rs1 = 5'd9;
    #1;
    chk("coll_busy", busy1, 1'b1);
    chk("coll_data", rd_data1, 32'hCAFE0009);

    for (int k = 0; k < 400; k++) begin
      regWr   = $urandom_range(0, 1);
      ws      = 5'($urandom_range(0, 15));
      wr_data = $urandom;
      rsv_en  = $urandom_range(0, 1);
      rsv_rd  = 5'($urandom_range(0, 15));
      rs1     = 5'($urandom_range(0, 15));
      rs2     = ($urandom_range(0, 3) == 0) ? ws : 5'($urandom_range(0, 15));
      check_ports("rnd");
      tick();
    end
    idle();

    set_reset(1'b0);
    rs1 = 5'd9;
    #1;
    chk("mid_run_rst_done", init_done, 1'b0);
    chk("mid_run_rst_rd", rd_data1, 32'h0);
    tick();
    set_reset(1'b1);
    for (int k = 0; k < 10; k++) tick();
    set_reset(1'b0);
    #1;
    chk("mid_clr_rst_done", init_done, 1'b0);
    tick();
    set_reset(1'b1);
    run_clear("restart", 1'b0);
    scan_all("restart_scan");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
